// File: rtl/ov7670_tx_pkg.sv
// Shared state encoding, RGB444 colour-bar constants and default timing for the OV7670 pixel source.
// No logic; imported by the pattern generator and the transmitter top.
package ov7670_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } tx_state_e;

  localparam logic [11:0] RGB_WHITE   = 12'hFFF;
  localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
  localparam logic [11:0] RGB_CYAN    = 12'h0FF;
  localparam logic [11:0] RGB_GREEN   = 12'h0F0;
  localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
  localparam logic [11:0] RGB_RED     = 12'hF00;
  localparam logic [11:0] RGB_BLUE    = 12'h00F;
  localparam logic [11:0] RGB_BLACK   = 12'h000;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_VBP_LINES   = 17;
  localparam int DEF_VFP_LINES   = 10;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov7670_pixel_tx_if.sv
// Camera-side pixel bus (byte, vsync, href) driven by the transmitter.
// master drives, slave observes; there is no backpressure on this bus.
interface ov7670_pixel_tx_if;
  logic [7:0] o_pix_byte;
  logic       o_vsync;
  logic       o_href;

  modport master (output o_pix_byte, output o_vsync, output o_href);
  modport slave  (input  o_pix_byte, input  o_vsync, input  o_href);
endinterface

// File: rtl/ov7670_pattern_gen.sv
// Combinational (pattern, x, y) -> RGB444 map: colour bars or x/y ramp.
// Zero latency; the parent registers and splits the result into bytes.
module ov7670_pattern_gen
  import ov7670_tx_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic          pattern,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [11:0]   rgb
);

  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar;

  always_comb begin
    bar = 3'(32'(x) / BAR_W);
    rgb = RGB_BLACK;
    if (pattern) begin
      rgb = {4'(x), 4'(y), 4'h0};
    end else begin
      case (bar)
        3'd0:    rgb = RGB_WHITE;
        3'd1:    rgb = RGB_YELLOW;
        3'd2:    rgb = RGB_CYAN;
        3'd3:    rgb = RGB_GREEN;
        3'd4:    rgb = RGB_MAGENTA;
        3'd5:    rgb = RGB_RED;
        3'd6:    rgb = RGB_BLUE;
        default: rgb = RGB_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/ov7670_pixel_tx.sv
// OV7670-style RGB444 frame source, one byte per i_clk; outputs registered one edge after the state they describe.
// Free-running once started (no backpressure); o_frame_cnt exists only with OV7670_TX_FRAME_CNT_EN defined.
module ov7670_pixel_tx
  import ov7670_tx_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int VBP_LINES   = DEF_VBP_LINES,
  parameter int VFP_LINES   = DEF_VFP_LINES
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_continuous,
  input  logic                     i_pattern,
  ov7670_pixel_tx_if.master        pix_if,
  output logic                     o_busy,
  output logic                     o_frame_done
`ifdef OV7670_TX_FRAME_CNT_EN
  ,
  output logic [15:0]              o_frame_cnt
`endif
);

  localparam int L         = 2 * (H_ACTIVE + H_BLANK);
  localparam int BW        = cnt_w(L);
  localparam int MAX_LINES = max_i(max_i(VSYNC_LINES, VBP_LINES), max_i(V_ACTIVE, VFP_LINES));
  localparam int LW        = cnt_w(MAX_LINES);
  localparam int XW        = cnt_w(H_ACTIVE);
  localparam int YW        = cnt_w(V_ACTIVE);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [LW-1:0] line_q, line_d;
  logic          pattern_q, pattern_d;
  logic [7:0]    pix_byte_q, pix_byte_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [LW-1:0] last_line;
  logic          eol, eop;
  logic [XW-1:0] x_d;
  logic [YW-1:0] y_d;
  logic [11:0]   rgb;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      byte_q     <= '0;
      line_q     <= '0;
      pattern_q  <= 1'b0;
      pix_byte_q <= 8'h00;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      line_q     <= line_d;
      pattern_q  <= pattern_d;
      pix_byte_q <= pix_byte_d;
      vsync_q    <= vsync_d;
      href_q     <= href_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Byte counter spans a whole line period; line counter restarts at every phase change.
  always_comb begin
    case (state_q)
      ST_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
      ST_VBP:    last_line = LW'(VBP_LINES - 1);
      ST_ACTIVE: last_line = LW'(V_ACTIVE - 1);
      ST_VFP:    last_line = LW'(VFP_LINES - 1);
      default:   last_line = '0;
    endcase
    eol       = (byte_q == BW'(L - 1));
    eop       = eol && (line_q == last_line);
    state_d   = state_q;
    byte_d    = byte_q;
    line_d    = line_q;
    pattern_d = pattern_q;
    if (state_q == ST_IDLE) begin
      if (i_start) begin
        state_d   = ST_VSYNC;
        pattern_d = i_pattern;
      end
    end else begin
      byte_d = eol ? '0 : byte_q + BW'(1);
      if (eop)      line_d = '0;
      else if (eol) line_d = line_q + LW'(1);
      if (eop) begin
        case (state_q)
          ST_VSYNC:  state_d = ST_VBP;
          ST_VBP:    state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFP;
          ST_VFP: begin
            if (i_continuous) begin
              state_d   = ST_VSYNC;
              pattern_d = i_pattern;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default:   state_d = ST_IDLE;
        endcase
      end
    end
  end

  ov7670_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW),
    .YW       (YW)
  ) u_pattern_gen (
    .pattern (pattern_q),
    .x       (x_d),
    .y       (y_d),
    .rgb     (rgb)
  );

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    x_d        = XW'(byte_d >> 1);
    y_d        = YW'(line_d);
    vsync_d    = (state_d == ST_VSYNC);
    href_d     = (state_d == ST_ACTIVE) && (byte_d < BW'(2 * H_ACTIVE));
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_VFP) && (byte_d == BW'(L - 1)) && (line_d == LW'(VFP_LINES - 1));
    pix_byte_d = 8'h00;
    if (href_d) pix_byte_d = byte_d[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
  end

  assign pix_if.o_pix_byte = pix_byte_q;
  assign pix_if.o_vsync    = vsync_q;
  assign pix_if.o_href     = href_q;
  assign o_busy            = busy_q;
  assign o_frame_done      = done_q;

`ifdef OV7670_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb frame_cnt_d = done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) frame_cnt_q <= 16'd0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/ov7670_pixel_tx.md
OV7670_PIXEL_TX -- requirements
Module: ov7670_pixel_tx

Interface
REQ-001 Parameter H_ACTIVE, 640, active pixels per line; SHALL be a multiple of 8.
REQ-002 Parameter V_ACTIVE, 480, active lines per frame.
REQ-003 Parameter H_BLANK, 144, blank pixel times per active line.
REQ-004 Parameters VSYNC_LINES 3, VBP_LINES 17, VFP_LINES 10: line counts of the vsync, back-porch and front-porch phases.
REQ-005 i_clk  in  1  sole clock; one output byte per rising edge, acting as camera PCLK.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_start  in  1  starts one frame when sampled high in IDLE.
REQ-008 i_continuous  in  1  when high at frame end, the next frame starts immediately.
REQ-009 i_pattern  in  1  0 = colour bars, 1 = x/y ramp; latched at frame start.
REQ-010 o_pix_byte  out  8  RGB444 pixel byte, OV7670 byte order.
REQ-011 o_vsync  out  1  frame sync, active-high.
REQ-012 o_href  out  1  line-valid, high only during active bytes.
REQ-013 o_busy  out  1  high in any state other than IDLE.
REQ-014 o_frame_done  out  1  single-cycle pulse on the last cycle of the front porch.

Function
REQ-015 All outputs SHALL be registered; the states SHALL be IDLE, VSYNC, VBP, ACTIVE and VFP.
REQ-016 Line period L SHALL be 2*(H_ACTIVE+H_BLANK) cycles in every non-IDLE state.
REQ-017 IDLE to VSYNC SHALL occur on the edge sampling i_start=1; o_vsync SHALL be high in the next cycle.
REQ-018 VSYNC SHALL last VSYNC_LINES*L cycles with o_vsync=1 and o_href=0.
REQ-019 VBP SHALL last VBP_LINES*L cycles and VFP SHALL last VFP_LINES*L cycles, both with o_vsync=0 and o_href=0.
REQ-020 ACTIVE SHALL last V_ACTIVE lines; each line SHALL have o_href=1 for 2*H_ACTIVE cycles, then o_href=0 for 2*H_BLANK cycles.
REQ-021 Each pixel SHALL be two bytes: first {4'h0,R[3:0]}, second {G[3:0],B[3:0]}; x SHALL advance every second byte; o_pix_byte SHALL be 8'h00 whenever o_href=0.
REQ-022 Colour bars: bar = x/(H_ACTIVE/8); order white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
REQ-023 Ramp: R=x[3:0], G=y[3:0], B=4'h0, where y is the active line index counted from 0.
REQ-024 At the end of VFP: if i_continuous=1, the block SHALL enter VSYNC directly with no idle cycle and re-latch i_pattern; otherwise it SHALL enter IDLE.
REQ-025 i_start while o_busy=1 SHALL be ignored; i_continuous dropping mid-frame SHALL let the current frame complete.
REQ-026 Counter widths SHALL be $clog2 of their maximum count and SHALL wrap to 0 at each phase or line boundary without overflow.

Reset
REQ-027 i_rst=1 SHALL force IDLE, clear all counters and drive o_pix_byte=0, o_vsync=0, o_href=0, o_busy=0 and o_frame_done=0 at the next edge, including mid-frame.
REQ-028 i_start sampled in the same cycle as i_rst SHALL be ignored.

Configuration
REQ-029 With OV7670_TX_FRAME_CNT_EN defined, the block SHALL add output o_frame_cnt (out, 16 bits), reset to 0, incrementing with wrap on each o_frame_done pulse.
REQ-030 Without OV7670_TX_FRAME_CNT_EN, the o_frame_cnt port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package ov7670_tx_pkg SHALL hold the state enum, the eight RGB444 bar constants and the default timing constants.
REQ-032 Sub-module ov7670_pattern_gen SHALL map (pattern, x, y) to a 12-bit RGB444 value combinationally; the parent SHALL register and split it into bytes.

Verification (H_ACTIVE=8, V_ACTIVE=2, H_BLANK=2, VSYNC/VBP/VFP_LINES=1, so L=20, frame=100 cycles)
REQ-033 Single frame: i_start pulse -> o_vsync high for 20 cycles, 20 quiet cycles, two lines of 16 href cycles plus 4 low, 20 cycles VFP, o_frame_done on cycle 100, then IDLE.
REQ-034 Colour bars: line 0 bytes -> 0F,FF, 0F,F0, 00,FF, 00,F0, 0F,0F, 0F,00, 00,0F, 00,00.
REQ-035 Ramp (i_pattern=1): line 1, pixel 5 -> bytes 05,10.
REQ-036 Continuous mode: i_continuous=1 -> o_vsync rises in the cycle after o_frame_done; clearing it in frame 2 -> IDLE after frame 2.
REQ-037 Reset at cycle 50 mid-ACTIVE -> all outputs 0 next cycle; i_start held during busy is ignored.
REQ-038 With OV7670_TX_FRAME_CNT_EN defined: three continuous frames -> o_frame_cnt = 3.
